// File: rtl/instr_encoder.sv
// Instruction encoder: packs symbolic requests into 9-bit {OpCode, Lower4} words and writes
// them sequentially into instruction memory. Define INSTR_ENC_LDI_EN to enable LDI expansion.
package definitions;
    localparam logic [4:0] LD   = 5'd0;
    localparam logic [4:0] ST   = 5'd1;
    localparam logic [4:0] ACC  = 5'd2;
    localparam logic [4:0] BCC  = 5'd3;
    localparam logic [4:0] MOV  = 5'd4;
    localparam logic [4:0] GET  = 5'd5;
    localparam logic [4:0] ADD  = 5'd6;
    localparam logic [4:0] SUB  = 5'd7;
    localparam logic [4:0] ADDC = 5'd8;
    localparam logic [4:0] SUBC = 5'd9;
    localparam logic [4:0] SHL  = 5'd10;
    localparam logic [4:0] SHR  = 5'd11;
    localparam logic [4:0] SHLC = 5'd12;
    localparam logic [4:0] SHRC = 5'd13;
    localparam logic [4:0] INC  = 5'd14;
    localparam logic [4:0] DEC  = 5'd15;
    localparam logic [4:0] MMM  = 5'd16;
    localparam logic [4:0] LLL  = 5'd17;
    localparam logic [4:0] CCC  = 5'd18;
    localparam logic [4:0] SET  = 5'd19;
    localparam logic [4:0] BEZ  = 5'd20;
    localparam logic [4:0] BNZ  = 5'd21;
    localparam logic [4:0] BEQ  = 5'd22;
    localparam logic [4:0] BNE  = 5'd23;
    localparam logic [4:0] BGT  = 5'd24;
    localparam logic [4:0] BLT  = 5'd25;
endpackage

module instr_encoder #(
    parameter int ADDR_W = 10
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Clear,
    input  logic              InValid,
    output logic              InReady,
    input  logic [4:0]        InOpCode,
    input  logic [7:0]        InOperand,
    input  logic              InLdi,
    output logic              WrEn,
    output logic [ADDR_W-1:0] WrAddr,
    output logic [8:0]        WrData,
    output logic [ADDR_W:0]   WordCount,
    output logic              Full,
    output logic              Error,
    output logic [1:0]        DbgState
);
    import definitions::*;

    // Handshake: a request transfers on every rising edge where InValid && InReady; the
    // requester holds its fields stable while InValid is high and InReady is low.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
`ifdef INSTR_ENC_LDI_EN
        EMIT_HI = 2'd1,
`endif
        FULL    = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

    state_t              r_state;
    state_t              w_state_nx;
    logic [ADDR_W:0]     r_count;
    logic [ADDR_W:0]     w_count_nx;
    logic [ADDR_W:0]     w_count_inc;
    logic                r_wr_en;
    logic                w_wr_en_nx;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [ADDR_W-1:0]   w_wr_addr_nx;
    logic [8:0]          r_wr_data;
    logic [8:0]          w_wr_data_nx;
    logic                r_error;
    logic                w_error_nx;
    logic                w_accept;
    logic                w_fills;
`ifdef INSTR_ENC_LDI_EN
    localparam logic [ADDR_W:0] LAST = CAP - 1'b1;
    logic [3:0]          r_hi;
    logic [3:0]          w_hi_nx;
    logic                w_last_slot;
`endif

    function automatic logic opcode_valid(input logic [4:0] op);
        case (op)
            LD, ST, ACC, BCC, MOV, GET, ADD, SUB, ADDC, SUBC, SHL, SHR, SHLC, SHRC,
            INC, DEC, MMM, LLL, CCC, SET, BEZ, BNZ, BEQ, BNE, BGT, BLT: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Clear also gates InReady so a request is never accepted and then wiped in the same edge.
    assign InReady     = (r_state == IDLE) && !Reset && !Clear;
    assign w_accept    = InValid && InReady;
    assign w_count_inc = r_count + 1'b1;
    assign w_fills     = (w_count_inc == CAP);
`ifdef INSTR_ENC_LDI_EN
    assign w_last_slot = (r_count == LAST);
`endif

    always_comb begin
        w_state_nx   = r_state;
        w_count_nx   = r_count;
        w_wr_en_nx   = 1'b0;
        w_wr_addr_nx = r_wr_addr;
        w_wr_data_nx = r_wr_data;
        w_error_nx   = r_error;
`ifdef INSTR_ENC_LDI_EN
        w_hi_nx      = r_hi;
`endif
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (InLdi) begin
`ifdef INSTR_ENC_LDI_EN
                        if ((InOperand[7:4] != 4'h0) && w_last_slot) begin
                            w_error_nx = 1'b1;
                        end else begin
                            w_wr_en_nx   = 1'b1;
                            w_wr_addr_nx = r_count[ADDR_W-1:0];
                            w_wr_data_nx = {ACC, InOperand[3:0]};
                            w_count_nx   = w_count_inc;
                            w_hi_nx      = InOperand[7:4];
                            if (InOperand[7:4] != 4'h0) begin
                                w_state_nx = EMIT_HI;
                            end else if (w_fills) begin
                                w_state_nx = FULL;
                            end
                        end
`else
                        w_error_nx = 1'b1;
`endif
                    end else if (opcode_valid(InOpCode) && (InOperand[7:4] == 4'h0)) begin
                        w_wr_en_nx   = 1'b1;
                        w_wr_addr_nx = r_count[ADDR_W-1:0];
                        w_wr_data_nx = {InOpCode, InOperand[3:0]};
                        w_count_nx   = w_count_inc;
                        if (w_fills) begin
                            w_state_nx = FULL;
                        end
                    end else begin
                        w_error_nx = 1'b1;
                    end
                end
            end
`ifdef INSTR_ENC_LDI_EN
            EMIT_HI: begin
                w_wr_en_nx   = 1'b1;
                w_wr_addr_nx = r_count[ADDR_W-1:0];
                w_wr_data_nx = {BCC, r_hi};
                w_count_nx   = w_count_inc;
                w_state_nx   = w_fills ? FULL : IDLE;
            end
`endif
            FULL: begin
                w_state_nx = FULL;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // Reset and Clear share one path; a pending BCC word is simply discarded.
    always_ff @(posedge Clk) begin
        if (Reset || Clear) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_error   <= 1'b0;
`ifdef INSTR_ENC_LDI_EN
            r_hi      <= 4'h0;
`endif
        end else begin
            r_state   <= w_state_nx;
            r_count   <= w_count_nx;
            r_wr_en   <= w_wr_en_nx;
            r_wr_addr <= w_wr_addr_nx;
            r_wr_data <= w_wr_data_nx;
            r_error   <= w_error_nx;
`ifdef INSTR_ENC_LDI_EN
            r_hi      <= w_hi_nx;
`endif
        end
    end

    assign WrEn      = r_wr_en;
    assign WrAddr    = r_wr_addr;
    assign WrData    = r_wr_data;
    assign WordCount = r_count;
    assign Full      = (r_state == FULL);
    assign Error     = r_error;
    assign DbgState  = r_state;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a 1024-word instance and a 4-word instance share stimulus.
module tb_instr_encoder;
    import definitions::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Clear = 1'b0;
    logic        InValid = 1'b0;
    logic [4:0]  InOpCode = '0;
    logic [7:0]  InOperand = '0;
    logic        InLdi = 1'b0;

    logic        b_InReady, b_WrEn, b_Full, b_Error;
    logic [9:0]  b_WrAddr;
    logic [8:0]  b_WrData;
    logic [10:0] b_WordCount;
    logic [1:0]  b_DbgState;

    logic        s_InReady, s_WrEn, s_Full, s_Error;
    logic [1:0]  s_WrAddr;
    logic [8:0]  s_WrData;
    logic [2:0]  s_WordCount;
    logic [1:0]  s_DbgState;

    int total = 0;
    int bad = 0;

    instr_encoder #(.ADDR_W(10)) u_big (
        .Clk(Clk), .Reset(Reset), .Clear(Clear), .InValid(InValid), .InReady(b_InReady),
        .InOpCode(InOpCode), .InOperand(InOperand), .InLdi(InLdi), .WrEn(b_WrEn),
        .WrAddr(b_WrAddr), .WrData(b_WrData), .WordCount(b_WordCount), .Full(b_Full),
        .Error(b_Error), .DbgState(b_DbgState)
    );

    instr_encoder #(.ADDR_W(2)) u_small (
        .Clk(Clk), .Reset(Reset), .Clear(Clear), .InValid(InValid), .InReady(s_InReady),
        .InOpCode(InOpCode), .InOperand(InOperand), .InLdi(InLdi), .WrEn(s_WrEn),
        .WrAddr(s_WrAddr), .WrData(s_WrData), .WordCount(s_WordCount), .Full(s_Full),
        .Error(s_Error), .DbgState(s_DbgState)
    );

    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [7:0] opd, input logic ldi);
        InValid = 1'b1; InOpCode = op; InOperand = opd; InLdi = ldi;
        tick();
        InValid = 1'b0; InOpCode = '0; InOperand = '0; InLdi = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        total++; if (b_InReady !== 1'b0) begin bad++; $display("FAIL reset_inready: got %0b want 0", b_InReady); end
        total++; if (b_WrEn !== 1'b0) begin bad++; $display("FAIL reset_wren: got %0b want 0", b_WrEn); end
        total++; if (b_WrAddr !== 10'd0) begin bad++; $display("FAIL reset_wraddr: got %0d want 0", b_WrAddr); end
        total++; if (b_WrData !== 9'd0) begin bad++; $display("FAIL reset_wrdata: got %h want 0", b_WrData); end
        total++; if (b_WordCount !== 11'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", b_WordCount); end
        total++; if (b_Full !== 1'b0) begin bad++; $display("FAIL reset_full: got %0b want 0", b_Full); end
        total++; if (b_Error !== 1'b0) begin bad++; $display("FAIL reset_error: got %0b want 0", b_Error); end
        total++; if (b_DbgState !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", b_DbgState); end
        Reset = 1'b0;
        #1;
        total++; if (b_InReady !== 1'b1) begin bad++; $display("FAIL reset_inready_after: got %0b want 1", b_InReady); end
    endtask

    task automatic test_single();
        logic [8:0] exp_w;
        exp_w = {ADD, 4'h3};
        drive(ADD, 8'h03, 1'b0);
        total++; if (b_WrEn !== 1'b1) begin bad++; $display("FAIL single_wren: got %0b want 1", b_WrEn); end
        total++; if (b_WrAddr !== 10'd0) begin bad++; $display("FAIL single_wraddr: got %0d want 0", b_WrAddr); end
        total++; if (b_WrData !== exp_w) begin bad++; $display("FAIL single_wrdata: got %h want %h", b_WrData, exp_w); end
        total++; if (b_WordCount !== 11'd1) begin bad++; $display("FAIL single_count: got %0d want 1", b_WordCount); end
        tick();
        total++; if (b_WrEn !== 1'b0) begin bad++; $display("FAIL single_pulse: got %0b want 0", b_WrEn); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] ops [3];
        logic [3:0] opds [3];
        logic [8:0] exp_w;
        ops = '{SUB, SHL, SET};
        opds = '{4'h1, 4'h2, 4'hF};
        for (int i = 0; i < 3; i++) begin
            InValid = 1'b1; InLdi = 1'b0; InOpCode = ops[i]; InOperand = {4'h0, opds[i]};
            tick();
            exp_w = {ops[i], opds[i]};
            total++; if (b_WrEn !== 1'b1) begin bad++; $display("FAIL b2b_wren[%0d]: got %0b want 1", i, b_WrEn); end
            total++; if (b_WrAddr !== 10'(i + 1)) begin bad++; $display("FAIL b2b_wraddr[%0d]: got %0d want %0d", i, b_WrAddr, i + 1); end
            total++; if (b_WrData !== exp_w) begin bad++; $display("FAIL b2b_wrdata[%0d]: got %h want %h", i, b_WrData, exp_w); end
        end
        InValid = 1'b0;
        total++; if (b_WordCount !== 11'd4) begin bad++; $display("FAIL b2b_count: got %0d want 4", b_WordCount); end
    endtask

    task automatic test_ldi();
        logic [8:0] exp_w;
        do_reset();
`ifdef INSTR_ENC_LDI_EN
        drive(5'd0, 8'hA5, 1'b1);
        exp_w = {ACC, 4'h5};
        total++; if (b_WrEn !== 1'b1) begin bad++; $display("FAIL ldi_lo_wren: got %0b want 1", b_WrEn); end
        total++; if (b_WrAddr !== 10'd0) begin bad++; $display("FAIL ldi_lo_wraddr: got %0d want 0", b_WrAddr); end
        total++; if (b_WrData !== exp_w) begin bad++; $display("FAIL ldi_lo_wrdata: got %h want %h", b_WrData, exp_w); end
        total++; if (b_InReady !== 1'b0) begin bad++; $display("FAIL ldi_inready_busy: got %0b want 0", b_InReady); end
        tick();
        exp_w = {BCC, 4'hA};
        total++; if (b_WrEn !== 1'b1) begin bad++; $display("FAIL ldi_hi_wren: got %0b want 1", b_WrEn); end
        total++; if (b_WrAddr !== 10'd1) begin bad++; $display("FAIL ldi_hi_wraddr: got %0d want 1", b_WrAddr); end
        total++; if (b_WrData !== exp_w) begin bad++; $display("FAIL ldi_hi_wrdata: got %h want %h", b_WrData, exp_w); end
        total++; if (b_InReady !== 1'b1) begin bad++; $display("FAIL ldi_inready_back: got %0b want 1", b_InReady); end
        drive(5'd0, 8'h07, 1'b1);
        exp_w = {ACC, 4'h7};
        total++; if (b_WrAddr !== 10'd2) begin bad++; $display("FAIL ldi_short_wraddr: got %0d want 2", b_WrAddr); end
        total++; if (b_WrData !== exp_w) begin bad++; $display("FAIL ldi_short_wrdata: got %h want %h", b_WrData, exp_w); end
        total++; if (b_InReady !== 1'b1) begin bad++; $display("FAIL ldi_short_inready: got %0b want 1", b_InReady); end
        tick();
        total++; if (b_WrEn !== 1'b0) begin bad++; $display("FAIL ldi_short_no_hi: got %0b want 0", b_WrEn); end
        total++; if (b_WordCount !== 11'd3) begin bad++; $display("FAIL ldi_count: got %0d want 3", b_WordCount); end
`else
        exp_w = 9'd0;
        drive(5'd0, 8'h12, 1'b1);
        total++; if (b_WrEn !== 1'b0) begin bad++; $display("FAIL ldi_off_wren: got %0b want 0", b_WrEn); end
        total++; if (b_Error !== 1'b1) begin bad++; $display("FAIL ldi_off_error: got %0b want 1", b_Error); end
        total++; if (b_WordCount !== 11'd0) begin bad++; $display("FAIL ldi_off_count: got %0d want 0", b_WordCount); end
        total++; if (b_WrData !== exp_w) begin bad++; $display("FAIL ldi_off_wrdata: got %h want %h", b_WrData, exp_w); end
`endif
    endtask

    task automatic test_error();
        logic [8:0] exp_w;
        do_reset();
        drive(INC, 8'h13, 1'b0);
        total++; if (b_WrEn !== 1'b0) begin bad++; $display("FAIL err_hi_nib_wren: got %0b want 0", b_WrEn); end
        total++; if (b_Error !== 1'b1) begin bad++; $display("FAIL err_hi_nib_error: got %0b want 1", b_Error); end
        drive(5'b11111, 8'h02, 1'b0);
        total++; if (b_WrEn !== 1'b0) begin bad++; $display("FAIL err_badop_wren: got %0b want 0", b_WrEn); end
        total++; if (b_WordCount !== 11'd0) begin bad++; $display("FAIL err_badop_count: got %0d want 0", b_WordCount); end
        drive(DEC, 8'h02, 1'b0);
        exp_w = {DEC, 4'h2};
        total++; if (b_WrEn !== 1'b1) begin bad++; $display("FAIL err_after_wren: got %0b want 1", b_WrEn); end
        total++; if (b_WrAddr !== 10'd0) begin bad++; $display("FAIL err_after_wraddr: got %0d want 0", b_WrAddr); end
        total++; if (b_WrData !== exp_w) begin bad++; $display("FAIL err_after_wrdata: got %h want %h", b_WrData, exp_w); end
        total++; if (b_Error !== 1'b1) begin bad++; $display("FAIL err_sticky: got %0b want 1", b_Error); end
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        #1;
        total++; if (b_Error !== 1'b0) begin bad++; $display("FAIL clear_error: got %0b want 0", b_Error); end
        total++; if (b_WordCount !== 11'd0) begin bad++; $display("FAIL clear_count: got %0d want 0", b_WordCount); end
        drive(LLL, 8'h04, 1'b0);
        exp_w = {LLL, 4'h4};
        total++; if (b_WrAddr !== 10'd0) begin bad++; $display("FAIL clear_restart_wraddr: got %0d want 0", b_WrAddr); end
        total++; if (b_WrData !== exp_w) begin bad++; $display("FAIL clear_restart_wrdata: got %h want %h", b_WrData, exp_w); end
    endtask

    task automatic test_full();
        logic [8:0] exp_w;
        do_reset();
        drive(LD, 8'h01, 1'b0);
        drive(ST, 8'h02, 1'b0);
        drive(GET, 8'h03, 1'b0);
        total++; if (s_WordCount !== 3'd3) begin bad++; $display("FAIL full_pre_count: got %0d want 3", s_WordCount); end
        total++; if (s_WrAddr !== 2'd2) begin bad++; $display("FAIL full_pre_wraddr: got %0d want 2", s_WrAddr); end
        total++; if (s_Full !== 1'b0) begin bad++; $display("FAIL full_pre_full: got %0b want 0", s_Full); end
        drive(5'd0, 8'h50, 1'b1);
        total++; if (s_WrEn !== 1'b0) begin bad++; $display("FAIL full_ldi_wren: got %0b want 0", s_WrEn); end
        total++; if (s_Error !== 1'b1) begin bad++; $display("FAIL full_ldi_error: got %0b want 1", s_Error); end
        total++; if (s_WordCount !== 3'd3) begin bad++; $display("FAIL full_ldi_count: got %0d want 3", s_WordCount); end
        total++; if (s_InReady !== 1'b1) begin bad++; $display("FAIL full_ldi_inready: got %0b want 1", s_InReady); end
        drive(MOV, 8'h01, 1'b0);
        exp_w = {MOV, 4'h1};
        total++; if (s_WrEn !== 1'b1) begin bad++; $display("FAIL full_last_wren: got %0b want 1", s_WrEn); end
        total++; if (s_WrAddr !== 2'd3) begin bad++; $display("FAIL full_last_wraddr: got %0d want 3", s_WrAddr); end
        total++; if (s_WrData !== exp_w) begin bad++; $display("FAIL full_last_wrdata: got %h want %h", s_WrData, exp_w); end
        total++; if (s_Full !== 1'b1) begin bad++; $display("FAIL full_flag: got %0b want 1", s_Full); end
        total++; if (s_InReady !== 1'b0) begin bad++; $display("FAIL full_inready: got %0b want 0", s_InReady); end
        total++; if (s_WordCount !== 3'd4) begin bad++; $display("FAIL full_count: got %0d want 4", s_WordCount); end
        total++; if (s_DbgState !== 2'd2) begin bad++; $display("FAIL full_state: got %0d want 2", s_DbgState); end
        drive(ADD, 8'h01, 1'b0);
        total++; if (s_WrEn !== 1'b0) begin bad++; $display("FAIL full_no_wrap_wren: got %0b want 0", s_WrEn); end
        total++; if (s_WordCount !== 3'd4) begin bad++; $display("FAIL full_no_wrap_count: got %0d want 4", s_WordCount); end
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        #1;
        total++; if (s_Full !== 1'b0) begin bad++; $display("FAIL full_clear_full: got %0b want 0", s_Full); end
        total++; if (s_InReady !== 1'b1) begin bad++; $display("FAIL full_clear_inready: got %0b want 1", s_InReady); end
        total++; if (s_Error !== 1'b0) begin bad++; $display("FAIL full_clear_error: got %0b want 0", s_Error); end
    endtask

`ifdef INSTR_ENC_LDI_EN
    task automatic test_reset_emit_hi();
        logic [8:0] exp_w;
        do_reset();
        drive(5'd0, 8'hF0, 1'b1);
        exp_w = {ACC, 4'h0};
        total++; if (b_WrData !== exp_w) begin bad++; $display("FAIL rst_hi_lo_wrdata: got %h want %h", b_WrData, exp_w); end
        Reset = 1'b1;
        tick();
        total++; if (b_WrEn !== 1'b0) begin bad++; $display("FAIL rst_hi_wren: got %0b want 0", b_WrEn); end
        total++; if (b_WrData !== 9'd0) begin bad++; $display("FAIL rst_hi_wrdata: got %h want 0", b_WrData); end
        total++; if (b_WordCount !== 11'd0) begin bad++; $display("FAIL rst_hi_count: got %0d want 0", b_WordCount); end
        Reset = 1'b0;
        tick();
        total++; if (b_WrEn !== 1'b0) begin bad++; $display("FAIL rst_hi_later_wren: got %0b want 0", b_WrEn); end
        total++; if (b_InReady !== 1'b1) begin bad++; $display("FAIL rst_hi_inready: got %0b want 1", b_InReady); end
        drive(5'd0, 8'hF0, 1'b1);
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        #1;
        total++; if (b_WrEn !== 1'b0) begin bad++; $display("FAIL clr_hi_wren: got %0b want 0", b_WrEn); end
        total++; if (b_WordCount !== 11'd0) begin bad++; $display("FAIL clr_hi_count: got %0d want 0", b_WordCount); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ldi();
        test_error();
        test_full();
`ifdef INSTR_ENC_LDI_EN
        test_reset_emit_hi();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Program-side counterpart to the core's instruction decode path. Accepts symbolic instructions (5-bit opcode from the `definitions` package plus an operand) over a valid/ready handshake, packs them into 9-bit machine words `{OpCode, Lower4}`, and writes them sequentially into instruction memory. Expands the `LDI` pseudo-op (8-bit constant to accumulator) into the `ACC`/`BCC` word pair the decoder expects. Used by the bench loader and the on-chip boot path to fill instruction memory before the core is released.

## Interface
- `ADDR_W`, default 10: instruction-memory address width; capacity = 2**ADDR_W words.
- `Clk` input 1: clock, all logic on rising edge.
- `Reset` input 1: synchronous, active-high.
- `Clear` input 1: synchronous; address, error and full state return to reset values. `Reset` has priority.
- `InValid` input 1: request present.
- `InReady` output 1: encoder can accept a request this cycle.
- `InOpCode` input 5: opcode from `definitions` (ignored when `InLdi`=1).
- `InOperand` input 8: register index or immediate.
- `InLdi` input 1: request is `LDI InOperand`.
- `WrEn` output 1: write strobe to instruction memory.
- `WrAddr` output ADDR_W: write address.
- `WrData` output 9: machine word.
- `WordCount` output ADDR_W+1: words written since reset/clear.
- `Full` output 1: memory full.
- `Error` output 1: sticky; an invalid request was rejected.

## Operation
- States: `IDLE`, `EMIT_HI`, `FULL`.
- Accept = `InValid && InReady`. `InReady` = 1 only in `IDLE` and not in reset.
- Normal request: valid opcode = any of LD, ST, ACC, BCC, MOV, GET, ADD, SUB, ADDC, SUBC, SHL, SHR, SHLC, SHRC, INC, DEC, MMM, LLL, CCC, SET, BEZ, BNZ, BEQ, BNE, BGT, BLT. `InOperand[7:4]` must be 0. Emits `{InOpCode, InOperand[3:0]}`.
- Invalid opcode or nonzero `InOperand[7:4]`: request consumed, nothing written, `Error` set; state stays `IDLE`.
- `LDI k`: word 1 `{ACC, k[3:0]}`; word 2 `{BCC, k[7:4]}` emitted from `EMIT_HI`. If `k[7:4]`==0, word 2 is omitted.
- `LDI` needing 2 words with only 1 free slot: consumed, nothing written, `Error` set.
- Address counter increments by 1 per written word; `WordCount` = counter. When `WordCount` reaches 2**ADDR_W, enter `FULL`: `Full`=1, `InReady`=0 until `Clear`/`Reset`. No wrap-around.
- `Error` only cleared by `Clear`/`Reset`; encoding continues after an error.

## Timing
- Reset values: `InReady`=0 during reset cycle then 1; `WrEn`=0, `WrAddr`=0, `WrData`=0, `WordCount`=0, `Full`=0, `Error`=0; state `IDLE`.
- Registered outputs: request accepted at edge N → `WrEn`=1 with `WrAddr`/`WrData` valid during cycle N+1 (1-cycle latency). `WrEn` is a single-cycle pulse per word.
- Two-word `LDI` accepted at edge N: `ACC` word in cycle N+1, `BCC` word (at address+1) in cycle N+2; `InReady`=0 in cycle N+1; next accept possible at edge N+2.
- Back-to-back single-word requests: one accept and one write per cycle.
- Rejected request: `Error`=1 from cycle N+1; `WrEn` stays 0.
- `Full` asserts in the cycle the last word is written.
- `Reset`/`Clear` during `EMIT_HI`: pending `BCC` word dropped, no write that cycle or after.

## Configuration
- `INSTR_ENC_LDI_EN` defined: `LDI` expansion and `EMIT_HI` state present as described.
- Undefined: `EMIT_HI` removed; any request with `InLdi`=1 is rejected (`Error` set, no write); `InLdi` input is otherwise ignored.

## Test plan
- Reset, then `ADD` operand 0x03 → cycle after accept: `WrEn`=1, `WrAddr`=0, `WrData`={ADD,4'h3}; `WordCount`=1.
- `LDI 0xA5` → `{ACC,4'h5}` at addr 0, `{BCC,4'hA}` at addr 1 on consecutive cycles, `InReady`=0 between; `LDI 0x07` → single `{ACC,4'h7}`.
- `INC` operand 0x13 and undefined opcode 5'b11111 → no writes, `Error`=1 sticky, next valid `DEC 0x2` still written at next address.
- `ADDR_W`=2: write 3 words, then `LDI 0x50` → rejected, `Error`=1; then `MOV 0x1` → written at addr 3, `Full`=1, `InReady`=0, `WordCount`=4.
- `Reset` asserted in the `EMIT_HI` cycle of `LDI 0xF0` → only `ACC` word written; all outputs at reset values next cycle; `Clear` after errors → `Error`=0, `WrAddr` restarts at 0.
- Build without `INSTR_ENC_LDI_EN`: `LDI 0x12` → no write, `Error`=1.
